// File: rtl/counter_binary_pkg.sv
// Shared helpers for the binary counter slice.
// Latency: n/a (elaboration-time constants only).
// Backpressure: n/a.
package counter_binary_pkg;

    // Ceiling log2 with a floor of 1 so a register width is never zero.
    function automatic int unsigned clog2_min1(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 31; i++) begin
            if ((32'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Divides enabled clk cycles down to a single-cycle tick every PRESCALE enabled cycles.
// Latency: tick is combinational from enable and the registered phase count.
// Backpressure: enable low freezes the phase count (holds, never clears).
module counter_prescaler
    import counter_binary_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int unsigned PW = clog2_min1(PRESCALE);
    // With PRESCALE=1 LAST is 0 and the phase register is stuck at 0,
    // so tick reduces to enable and the flop is optimised away.
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] phase_q;
    logic [PW-1:0] phase_d;

    // Tick on the final phase of each enabled period; advance or wrap only while enabled.
    always_comb begin
        tick    = enable && (phase_q == LAST);
        phase_d = phase_q;
        if (enable) begin
            phase_d = tick ? '0 : phase_q + PW'(1'b1);
        end
    end

    // Phase register, cleared immediately by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/counter_binary_top.sv
// Free-running up-counter 0..MAX_COUNT with enable, optional prescaler and terminal-count carry.
// Latency: counter updates one clk edge after a tick; carry is combinational in the wrap cycle.
// Backpressure: enable low holds counter and prescaler; carry is suppressed while held.
module counter_binary_top
    import counter_binary_pkg::*;
#(
    parameter int unsigned        NBITS     = 4,
    parameter logic [NBITS-1:0]   MAX_COUNT = {NBITS{1'b1}},
    parameter int unsigned        PRESCALE  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic             carry,
    output logic [NBITS-1:0] counter
);

    logic             tick;
    logic             at_max;
    logic [NBITS-1:0] counter_q;
    logic [NBITS-1:0] counter_d;

    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .tick   (tick)
    );

    // Step on tick, wrapping after MAX_COUNT; carry flags the wrapping step.
    always_comb begin
        at_max    = (counter_q == MAX_COUNT);
        carry     = tick && at_max;
        counter_d = counter_q;
        if (tick) begin
            counter_d = at_max ? '0 : counter_q + NBITS'(1'b1);
        end
    end

    // Count register, cleared immediately by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter_q <= '0;
        end else begin
            counter_q <= counter_d;
        end
    end

    assign counter = counter_q;

endmodule

// File: tb/tb_counter_binary_top.sv
// Directed bench: default counter (NBITS=4, MAX=15, PRESCALE=1) and a
// prescaled decade counter (NBITS=4, MAX=9, PRESCALE=3) sharing clk and reset.
// Outputs are sampled 1 ns after each rising edge; inputs change at the same point.
module tb_counter_binary_top;

    logic       clk;
    logic       reset;
    logic       en_a;
    logic       en_b;
    logic       carry_a;
    logic       carry_b;
    logic [3:0] cnt_a;
    logic [3:0] cnt_b;

    int n_cmp;
    int n_fail;

    counter_binary_top #(
        .NBITS     (4),
        .MAX_COUNT (4'd15),
        .PRESCALE  (1)
    ) dut_a (
        .clk     (clk),
        .reset   (reset),
        .enable  (en_a),
        .carry   (carry_a),
        .counter (cnt_a)
    );

    counter_binary_top #(
        .NBITS     (4),
        .MAX_COUNT (4'd9),
        .PRESCALE  (3)
    ) dut_b (
        .clk     (clk),
        .reset   (reset),
        .enable  (en_b),
        .carry   (carry_b),
        .counter (cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick_edge();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        en_a = 1'b1;
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick_edge();
            n_cmp++;
            if (cnt_a !== 4'd0) begin
                n_fail++;
                $display("FAIL reset_cnt cyc%0d: got %0d want 0", i, cnt_a);
            end
            n_cmp++;
            if (carry_a !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_carry cyc%0d: got %b want 0", i, carry_a);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_sequence();
        logic [3:0] exp;
        for (int i = 1; i <= 16; i++) begin
            tick_edge();
            exp = 4'(i % 16);
            n_cmp++;
            if (cnt_a !== exp) begin
                n_fail++;
                $display("FAIL seq_cnt step%0d: got %0d want %0d", i, cnt_a, exp);
            end
            n_cmp++;
            if (carry_a !== (exp == 4'd15)) begin
                n_fail++;
                $display("FAIL seq_carry step%0d: got %b want %b", i, carry_a, exp == 4'd15);
            end
        end
    endtask

    task automatic test_forty_cycles();
        int pulses;
        pulses = 0;
        do_reset();
        en_a = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (carry_a === 1'b1) pulses++;
            tick_edge();
        end
        n_cmp++;
        if (pulses !== 2) begin
            n_fail++;
            $display("FAIL forty_pulses: got %0d want 2", pulses);
        end
        n_cmp++;
        if (cnt_a !== 4'd8) begin
            n_fail++;
            $display("FAIL forty_cnt: got %0d want 8", cnt_a);
        end
    endtask

    task automatic test_enable_hold();
        do_reset();
        en_a = 1'b1;
        repeat (7) tick_edge();
        en_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick_edge();
            n_cmp++;
            if (cnt_a !== 4'd7 || carry_a !== 1'b0) begin
                n_fail++;
                $display("FAIL hold7 cyc%0d: got cnt=%0d carry=%b want cnt=7 carry=0", i, cnt_a, carry_a);
            end
        end
        en_a = 1'b1;
        tick_edge();
        n_cmp++;
        if (cnt_a !== 4'd8) begin
            n_fail++;
            $display("FAIL resume8: got %0d want 8", cnt_a);
        end
        tick_edge();
        n_cmp++;
        if (cnt_a !== 4'd9) begin
            n_fail++;
            $display("FAIL resume9: got %0d want 9", cnt_a);
        end
    endtask

    task automatic test_hold_at_max();
        repeat (6) tick_edge();
        n_cmp++;
        if (cnt_a !== 4'd15 || carry_a !== 1'b1) begin
            n_fail++;
            $display("FAIL reach15: got cnt=%0d carry=%b want cnt=15 carry=1", cnt_a, carry_a);
        end
        en_a = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (cnt_a !== 4'd15 || carry_a !== 1'b0) begin
                n_fail++;
                $display("FAIL maxhold cyc%0d: got cnt=%0d carry=%b want cnt=15 carry=0", i, cnt_a, carry_a);
            end
            tick_edge();
        end
        en_a = 1'b1;
        #1;
        n_cmp++;
        if (carry_a !== 1'b1) begin
            n_fail++;
            $display("FAIL max_reenable_carry: got %b want 1", carry_a);
        end
        tick_edge();
        n_cmp++;
        if (cnt_a !== 4'd0 || carry_a !== 1'b0) begin
            n_fail++;
            $display("FAIL max_wrap: got cnt=%0d carry=%b want cnt=0 carry=0", cnt_a, carry_a);
        end
    endtask

    task automatic test_async_reset();
        repeat (9) tick_edge();
        n_cmp++;
        if (cnt_a !== 4'd9) begin
            n_fail++;
            $display("FAIL pre_async: got %0d want 9", cnt_a);
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (cnt_a !== 4'd0 || carry_a !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got cnt=%0d carry=%b want cnt=0 carry=0", cnt_a, carry_a);
        end
        tick_edge();
        reset = 1'b0;
        en_a = 1'b0;
    endtask

    task automatic test_prescale();
        int pulses;
        logic [3:0] exp;
        pulses = 0;
        do_reset();
        en_b = 1'b1;
        for (int i = 0; i < 60; i++) begin
            exp = 4'((i / 3) % 10);
            n_cmp++;
            if (cnt_b !== exp) begin
                n_fail++;
                $display("FAIL pre_cnt cyc%0d: got %0d want %0d", i, cnt_b, exp);
            end
            n_cmp++;
            if (carry_b !== ((i % 30) == 29)) begin
                n_fail++;
                $display("FAIL pre_carry cyc%0d: got %b want %b", i, carry_b, (i % 30) == 29);
            end
            if (carry_b === 1'b1) pulses++;
            tick_edge();
        end
        n_cmp++;
        if (pulses !== 2) begin
            n_fail++;
            $display("FAIL pre_pulses: got %0d want 2", pulses);
        end
        // Stop mid-period: phase must be remembered across the pause.
        repeat (4) tick_edge();
        en_b = 1'b0;
        repeat (5) tick_edge();
        n_cmp++;
        if (cnt_b !== 4'd1) begin
            n_fail++;
            $display("FAIL pre_hold: got %0d want 1", cnt_b);
        end
        en_b = 1'b1;
        repeat (2) tick_edge();
        n_cmp++;
        if (cnt_b !== 4'd2) begin
            n_fail++;
            $display("FAIL pre_phase_kept: got %0d want 2", cnt_b);
        end
        en_b = 1'b0;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        reset  = 1'b1;
        en_a   = 1'b0;
        en_b   = 1'b0;
        test_reset();
        test_sequence();
        test_forty_cycles();
        test_enable_hold();
        test_hold_at_max();
        test_async_reset();
        test_prescale();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
